// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sonar_pkg
// Description : Shared state encoding, default timing constants and helpers
//               for the ultrasonic ranging sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_CYC_PER_CM  = 2900;
  localparam int DEF_RISE_TO_CYC = 1_500_000;
  localparam int DEF_MAX_CM      = 400;
  localparam int DEF_PERIOD_CYC  = 3_000_000;
  localparam int DEF_NEAR_CM     = 5;

  localparam int CM_W = 16;

  // Counter width able to hold the largest cycle count handed in.
  function automatic int count_width(input int a, input int b, input int c,
                                     input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_sync.sv
`default_nettype none
// ============================================================================
// Module      : echo_sync
// Description : Two-flop synchronizer bringing the asynchronous echo into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/sonar_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sonar_sequencer
// Description : Trigger / echo-timing sequencer for an ultrasonic ranger;
//               converts echo width to centimetres with a wrap counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_sequencer
  import sonar_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int RISE_TO_CYC = DEF_RISE_TO_CYC,
  parameter int MAX_CM      = DEF_MAX_CM,
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int NEAR_CM     = DEF_NEAR_CM
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            stop,
  input  logic            echo,
  output logic            trigger,
  output logic [CM_W-1:0] cm,
  output logic            cm_valid,
  output logic            timeout,
  output logic            near,
  output logic            busy
);

  localparam int CNT_W = count_width(CLK_HZ, PERIOD_CYC, RISE_TO_CYC,
                                     TRIG_CYC, CYC_PER_CM);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TO_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CPC_LAST    = CNT_W'(CYC_PER_CM - 1);
  localparam logic [CM_W-1:0]  MAX_CM_L    = CM_W'(MAX_CM);
  localparam logic [CM_W-1:0]  NEAR_CM_L   = CM_W'(NEAR_CM);

  state_t           state_q,     state_d;
  logic             trigger_q,   trigger_d;
  logic [CM_W-1:0]  cm_q,        cm_d;
  logic             cm_valid_q,  cm_valid_d;
  logic             timeout_q,   timeout_d;
  logic             near_q,      near_d;
  logic [CNT_W-1:0] period_q,    period_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] sub_q,       sub_d;
  logic [CM_W-1:0]  cm_cnt_q,    cm_cnt_d;
  logic             echo_prev_q, echo_prev_d;

  logic             echo_s;
  logic             echo_rise;
  logic             echo_fall;
  logic             start_ok;
  logic [CNT_W-1:0] base_sub;
  logic [CM_W-1:0]  base_cm;
  logic             tick_wrap;
  logic [CNT_W-1:0] tick_sub;
  logic [CM_W-1:0]  tick_cm;

  echo_sync u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  assign echo_rise = echo_s & ~echo_prev_q;
  assign echo_fall = ~echo_s & echo_prev_q;
  assign start_ok  = enable & ~stop;

  // The rising-edge cycle is itself the first high cycle, so counting starts
  // from zero there and continues from the held counters inside MEASURE.
  always_comb begin
    base_sub  = (state_q == ST_MEASURE) ? sub_q : '0;
    base_cm   = (state_q == ST_MEASURE) ? cm_cnt_q : '0;
    tick_wrap = (base_sub == CPC_LAST);
    tick_sub  = tick_wrap ? '0 : base_sub + 1'b1;
    tick_cm   = tick_wrap ? base_cm + 1'b1 : base_cm;
  end

  always_comb begin
    state_d     = state_q;
    trigger_d   = trigger_q;
    cm_d        = cm_q;
    cm_valid_d  = 1'b0;
    timeout_d   = 1'b0;
    near_d      = near_q;
    period_d    = (period_q >= PERIOD_LAST) ? period_q : period_q + 1'b1;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    cm_cnt_d    = cm_cnt_q;
    echo_prev_d = echo_s;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_TRIG;
          trigger_d = 1'b1;
          period_d  = '0;
          cnt_d     = '0;
        end
      end

      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d   = ST_WAIT_RISE;
          trigger_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_d  = ST_MEASURE;
          sub_d    = tick_sub;
          cm_cnt_d = tick_cm;
        end else if (cnt_q == RISE_LAST) begin
          state_d   = ST_HOLDOFF;
          timeout_d = 1'b1;
          near_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (echo_fall) begin
          state_d = ST_HOLDOFF;
          if (cm_cnt_q >= MAX_CM_L) begin
            timeout_d = 1'b1;
            near_d    = 1'b0;
          end else begin
            cm_d       = cm_cnt_q;
            cm_valid_d = 1'b1;
            near_d     = (cm_cnt_q <= NEAR_CM_L);
          end
        end else if (tick_cm >= MAX_CM_L) begin
          state_d   = ST_HOLDOFF;
          timeout_d = 1'b1;
          near_d    = 1'b0;
        end else begin
          sub_d    = tick_sub;
          cm_cnt_d = tick_cm;
        end
      end

      ST_HOLDOFF: begin
        if (period_q >= PERIOD_LAST) begin
          if (start_ok) begin
            state_d   = ST_TRIG;
            trigger_d = 1'b1;
            period_d  = '0;
            cnt_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        trigger_d = 1'b0;
      end
    endcase

    // Abort wins over every transition but keeps the last good result.
    if (stop) begin
      state_d    = ST_IDLE;
      trigger_d  = 1'b0;
      cm_valid_d = 1'b0;
      timeout_d  = 1'b0;
      cm_d       = cm_q;
      near_d     = near_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      trigger_q   <= 1'b0;
      cm_q        <= '0;
      cm_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
      near_q      <= 1'b0;
      period_q    <= '0;
      cnt_q       <= '0;
      sub_q       <= '0;
      cm_cnt_q    <= '0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trigger_q   <= trigger_d;
      cm_q        <= cm_d;
      cm_valid_q  <= cm_valid_d;
      timeout_q   <= timeout_d;
      near_q      <= near_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      cm_cnt_q    <= cm_cnt_d;
      echo_prev_q <= echo_prev_d;
    end
  end

  assign trigger  = trigger_q;
  assign cm       = cm_q;
  assign cm_valid = cm_valid_q;
  assign timeout  = timeout_q;
  assign near     = near_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sonar_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonar_sequencer
// Description : Directed self-checking bench for sonar_sequencer using scaled
//               timing (5-cycle trigger, 10 cycles/cm, 1000-cycle period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonar_sequencer;

  localparam int TRIG_CYC    = 5;
  localparam int CYC_PER_CM  = 10;
  localparam int RISE_TO_CYC = 200;
  localparam int MAX_CM      = 40;
  localparam int PERIOD_CYC  = 1000;
  localparam int NEAR_CM     = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        stop;
  logic        echo;
  logic        trigger;
  logic [15:0] cm;
  logic        cm_valid;
  logic        timeout;
  logic        near;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cv_cnt   = 0;
  int to_cnt   = 0;
  int both_cnt = 0;
  int trig_cnt = 0;
  logic trig_prev = 1'b0;

  sonar_sequencer #(
    .CLK_HZ      (50_000_000),
    .TRIG_CYC    (TRIG_CYC),
    .CYC_PER_CM  (CYC_PER_CM),
    .RISE_TO_CYC (RISE_TO_CYC),
    .MAX_CM      (MAX_CM),
    .PERIOD_CYC  (PERIOD_CYC),
    .NEAR_CM     (NEAR_CM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .stop     (stop),
    .echo     (echo),
    .trigger  (trigger),
    .cm       (cm),
    .cm_valid (cm_valid),
    .timeout  (timeout),
    .near     (near),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cm_valid === 1'b1) cv_cnt++;
    if (timeout === 1'b1) to_cnt++;
    if (cm_valid === 1'b1 && timeout === 1'b1) both_cnt++;
    if (trigger === 1'b1 && trig_prev !== 1'b1) trig_cnt++;
    trig_prev = trigger;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0 trigger high, 1 trigger low, 2 cm_valid, 3 timeout
  task automatic wait_for(input int which, input int limit, input string tag);
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (n < limit && hit !== 1'b1) begin
      case (which)
        0:       hit = (trigger === 1'b1);
        1:       hit = (trigger === 1'b0);
        2:       hit = (cm_valid === 1'b1);
        default: hit = (timeout === 1'b1);
      endcase
      if (hit !== 1'b1) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    assert (hit === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=no-event expected=event-within-%0d-cycles", tag, limit);
    end
  endtask

  task automatic measure(input int high, input string tag, output int t_rise);
    wait_for(0, 1100, {tag, "_trig_rise"});
    t_rise = cyc;
    wait_for(1, 20, {tag, "_trig_fall"});
    tick(3);
    echo = 1'b1;
    tick(high);
    echo = 1'b0;
    wait_for(2, 20, {tag, "_cm_valid"});
  endtask

  initial begin
    int t0, t1, tf, snap_cv, snap_to, snap_trig;

    reset  = 1'b1;
    enable = 1'b0;
    stop   = 1'b0;
    echo   = 1'b0;
    tick(3);
    chk("rst_trigger",  32'(trigger),  0);
    chk("rst_cm",       32'(cm),       0);
    chk("rst_cm_valid", 32'(cm_valid), 0);
    chk("rst_timeout",  32'(timeout),  0);
    chk("rst_near",     32'(near),     0);
    chk("rst_busy",     32'(busy),     0);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", 32'(busy), 0);

    // 100 high cycles -> 10 cm, single valid pulse, trigger width and period
    enable = 1'b1;
    wait_for(0, 5, "m1_trig_rise");
    t0 = cyc;
    chk("m1_busy", 32'(busy), 1);
    wait_for(1, 20, "m1_trig_fall");
    chk("m1_trig_width", 32'(cyc - t0), TRIG_CYC);
    tick(3);
    snap_cv = cv_cnt;
    echo = 1'b1;
    tick(100);
    echo = 1'b0;
    wait_for(2, 20, "m1_cm_valid");
    chk("m1_cm",      32'(cm),      10);
    chk("m1_near",    32'(near),    0);
    chk("m1_timeout", 32'(timeout), 0);
    tick(5);
    chk("m1_valid_once", 32'(cv_cnt - snap_cv), 1);

    measure(50, "m2", t1);
    chk("period", 32'(t1 - t0), PERIOD_CYC);
    chk("m2_cm",   32'(cm),   5);
    chk("m2_near", 32'(near), 1);

    measure(60, "m3", t0);
    chk("m3_cm",   32'(cm),   6);
    chk("m3_near", 32'(near), 0);

    measure(59, "m4", t1);
    chk("m4_cm",   32'(cm),   5);
    chk("m4_near", 32'(near), 1);

    // no echo: rise timeout exactly RISE_TO_CYC after trigger falls
    wait_for(0, 1100, "to_trig_rise");
    wait_for(1, 20, "to_trig_fall");
    tf = cyc;
    snap_cv = cv_cnt;
    wait_for(3, 250, "to_timeout");
    chk("rise_to_latency", 32'(cyc - tf), RISE_TO_CYC);
    chk("rise_to_cm",   32'(cm),   5);
    chk("rise_to_near", 32'(near), 0);
    chk("rise_to_no_valid", 32'(cv_cnt - snap_cv), 0);

    // echo held past MAX_CM: range timeout while echo still high
    wait_for(0, 1100, "max_trig_rise");
    wait_for(1, 20, "max_trig_fall");
    tick(3);
    snap_cv = cv_cnt;
    snap_to = to_cnt;
    echo = 1'b1;
    tf = cyc;
    wait_for(3, 500, "max_timeout");
    chk("max_to_window", 32'((cyc - tf >= MAX_CM * CYC_PER_CM) && (cyc - tf <= MAX_CM * CYC_PER_CM + 5)), 1);
    tick(40);
    echo = 1'b0;
    tick(5);
    chk("max_cm",       32'(cm),   5);
    chk("max_near",     32'(near), 0);
    chk("max_no_valid", 32'(cv_cnt - snap_cv), 0);
    chk("max_to_once",  32'(to_cnt - snap_to), 1);

    // stop during MEASURE aborts immediately and blocks new triggers
    wait_for(0, 1100, "stop_trig_rise");
    wait_for(1, 20, "stop_trig_fall");
    tick(3);
    echo = 1'b1;
    tick(30);
    snap_cv   = cv_cnt;
    snap_to   = to_cnt;
    snap_trig = trig_cnt;
    stop = 1'b1;
    tick(1);
    chk("stop_busy",    32'(busy),    0);
    chk("stop_trigger", 32'(trigger), 0);
    tick(20);
    echo = 1'b0;
    tick(1500);
    chk("stop_no_valid",   32'(cv_cnt - snap_cv),     0);
    chk("stop_no_timeout", 32'(to_cnt - snap_to),     0);
    chk("stop_no_trigger", 32'(trig_cnt - snap_trig), 0);
    chk("stop_cm",   32'(cm),   5);
    chk("stop_near", 32'(near), 0);

    // enable dropped mid-cycle: measurement completes, then back to IDLE
    stop = 1'b0;
    wait_for(0, 5, "en_trig_rise");
    enable = 1'b0;
    tick(1);
    snap_trig = trig_cnt;
    wait_for(1, 20, "en_trig_fall");
    tick(3);
    echo = 1'b1;
    tick(70);
    echo = 1'b0;
    wait_for(2, 20, "en_cm_valid");
    chk("en_cm",   32'(cm),   7);
    chk("en_near", 32'(near), 0);
    tick(1200);
    chk("en_idle_busy", 32'(busy), 0);
    chk("en_no_retrigger", 32'(trig_cnt - snap_trig), 0);

    // reset during TRIG drops trigger and clears results on that edge
    enable = 1'b1;
    wait_for(0, 5, "rt_trig_rise");
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rt_trigger",  32'(trigger),  0);
    chk("rt_cm",       32'(cm),       0);
    chk("rt_near",     32'(near),     0);
    chk("rt_busy",     32'(busy),     0);
    chk("rt_cm_valid", 32'(cm_valid), 0);
    chk("rt_timeout",  32'(timeout),  0);
    reset = 1'b0;
    wait_for(0, 5, "rt2_trig_rise");
    t0 = cyc;
    wait_for(1, 20, "rt2_trig_fall");
    chk("rt2_trig_width", 32'(cyc - t0), TRIG_CYC);
    tick(3);
    echo = 1'b1;
    tick(30);
    echo = 1'b0;
    wait_for(2, 20, "rt2_cm_valid");
    chk("rt2_cm",   32'(cm),   3);
    chk("rt2_near", 32'(near), 1);

    chk("valid_timeout_exclusive", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sonar_sequencer.md
SONAR_SEQUENCER -- requirements
Module: sonar_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter TRIG_CYC, default 500, meaning the trigger pulse width in cycles (10 us).
REQ-003 SHALL have parameter CYC_PER_CM, default 2900, meaning echo-high cycles per centimetre (58 us).
REQ-004 SHALL have parameter RISE_TO_CYC, default 1_500_000, meaning the echo-rise timeout in cycles (30 ms).
REQ-005 SHALL have parameter MAX_CM, default 400, meaning the range limit in cm.
REQ-006 SHALL have parameter PERIOD_CYC, default 3_000_000, meaning the trigger-to-trigger period in cycles (60 ms).
REQ-007 SHALL have parameter NEAR_CM, default 5, meaning the proximity threshold in cm.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port enable, input, 1 bit: permits new measurement cycles.
REQ-011 SHALL have port stop, input, 1 bit: aborts the current cycle immediately and blocks new ones.
REQ-012 SHALL have port echo, input, 1 bit: asynchronous sensor echo.
REQ-013 SHALL have port trigger, output, 1 bit: sensor trigger, registered.
REQ-014 SHALL have port cm, output, 16 bits: last valid distance.
REQ-015 SHALL have port cm_valid, output, 1 bit: one-cycle pulse when cm updates.
REQ-016 SHALL have port timeout, output, 1 bit: one-cycle pulse when a measurement fails.
REQ-017 SHALL have port near, output, 1 bit: registered flag meaning last result <= NEAR_CM.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 SHALL pass echo through a 2-flop synchronizer; all echo decisions use the synchronized value and its registered previous value (edge detect).
REQ-020 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE and HOLDOFF.
REQ-021 IDLE SHALL go to TRIG when enable=1 and stop=0; a period counter SHALL clear on TRIG entry.
REQ-022 TRIG SHALL drive trigger=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE with trigger=0.
REQ-023 WAIT_RISE SHALL go to MEASURE on a synced rising edge, and to HOLDOFF with a timeout pulse if RISE_TO_CYC cycles elapse first.
REQ-024 MEASURE SHALL use a sub-counter that wraps at CYC_PER_CM-1 and increments a cm counter on each wrap, so cm = floor(high_cycles/CYC_PER_CM); no divider is used.
REQ-025 On a synced falling edge in MEASURE: cm <= cm counter, cm_valid=1 on the next cycle, near <= (count <= NEAR_CM), then go to HOLDOFF.
REQ-026 If the cm counter reaches MAX_CM while echo is still high, SHALL pulse timeout, leave cm unchanged, clear near and go to HOLDOFF.
REQ-027 A timeout from WAIT_RISE SHALL also clear near and leave cm unchanged.
REQ-028 HOLDOFF SHALL wait until the period counter reaches PERIOD_CYC-1, then go to TRIG if enable=1 and stop=0, else to IDLE.
REQ-029 stop=1 in any state SHALL force IDLE on the next cycle with trigger=0, no cm_valid and no timeout; cm and near are retained.
REQ-030 enable=0 mid-cycle SHALL NOT abort the cycle; the current measurement completes, then the block returns to IDLE.
REQ-031 cm_valid and timeout SHALL never be high in the same cycle.
REQ-032 stop and reset SHALL both take precedence over every transition, with reset over stop.

Reset
REQ-033 On reset=1 at a clk edge: state=IDLE, trigger=0, cm=0, cm_valid=0, timeout=0, near=0, busy=0, all counters and synchronizer flops=0.
REQ-034 reset asserted mid-TRIG SHALL drop trigger on the same edge.

Structure
REQ-035 The state encoding and default timing constants SHALL live in shared package sonar_pkg.
REQ-036 The synchronizer SHALL be the single sub-module echo_sync, which is 2-flop and parameter-free.

Verification
REQ-037 With enable=1 and echo high for 29_000 cycles after the trigger: cm=10, cm_valid pulses once, near=0.
REQ-038 With echo high for 14_500 cycles: cm=5, near=1; with echo high for 17_400 cycles: cm=6, near=0.
REQ-039 With echo never rising: timeout pulses 1_500_000 cycles after the trigger falls, cm retains its prior value, near=0.
REQ-040 With enable held at 1: successive trigger rising edges are exactly 3_000_000 cycles apart, and each trigger pulse is 500 cycles wide.
REQ-041 With stop=1 at echo-high cycle 10_000: state=IDLE next cycle, no cm_valid, busy=0, and no trigger while stop=1.
REQ-042 With reset=1 during TRIG: trigger=0 and all outputs equal the values in REQ-033 after that edge; the next cycle starts cleanly once reset drops.
